hilo_sequencer: RTL and testbench
=================================

HILO_SEQUENCER -- requirements
Module: hilo_sequencer

Interface
REQ-001 Parameter DIV_LATENCY, default 33: divider cycles from DivControl sample edge to a valid DivHiIn/DivLoIn; legal range 1..63.
REQ-002 Parameter MULT_LATENCY, default 33: multiplier cycles from MultControl sample edge to a valid MultHiIn/MultLoIn; legal range 1..63.
REQ-003 Port `clk` input 1: single clock; all state changes on the rising edge.
REQ-004 Port `Reset` input 1: asynchronous, active-high reset.
REQ-005 Port `Start` input 1: operation request, sampled on the rising edge.
REQ-006 Port `Op` input 2: operation code; 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-007 Port `RsVal` input 32: first operand (dividend/multiplicand; MTHI/MTLO data).
REQ-008 Port `RtVal` input 32: second operand (divisor/multiplier).
REQ-009 Port `Abort` input 1: synchronous cancel of an in-flight operation.
REQ-010 Ports `MultHiIn`, `MultLoIn`, `DivHiIn`, `DivLoIn` input 32 each: unit result words.
REQ-011 Ports `AOut`, `BOut` output 32 each: registered operands held stable to both units.
REQ-012 Ports `MultControl`, `DivControl` output 1 each: one-cycle launch pulses to the units.
REQ-013 Port `UnitReset` output 1: one-cycle reset pulse to both units after Abort.
REQ-014 Ports `HiOut`, `LoOut` output 32 each: architectural Hi/Lo registers.
REQ-015 Port `Busy` output 1: MULT/DIV in flight.
REQ-016 Port `Done` output 1: one-cycle commit pulse.
REQ-017 Port `DivZeroExc` output 1: one-cycle divide-by-zero exception pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, LAUNCH, RUN and COMMIT, encoded in 2 bits.
REQ-019 In IDLE, at an edge with Start=1 and Op=MULT, or with Op=DIV and RtVal!=0, the block SHALL latch RsVal/RtVal into AOut/BOut, latch Op, and go to LAUNCH.
REQ-020 In LAUNCH, the block SHALL assert for exactly one cycle either MultControl (MULT) or DivControl (DIV).
REQ-021 In LAUNCH, the block SHALL load the 6-bit counter with the matching latency parameter and go to RUN at the next edge.
REQ-022 In RUN, the counter SHALL decrement on each edge, and the FSM SHALL go to COMMIT at the edge where the counter reaches 0.
REQ-023 In COMMIT, the block SHALL load HiOut/LoOut from the selected unit's Hi/Lo inputs at the next edge, go to IDLE, and assert Done for the following cycle.
REQ-024 Busy SHALL be high in LAUNCH, RUN and COMMIT, and low in IDLE.
REQ-025 Start SHALL be ignored while Busy=1, including MTHI/MTLO.
REQ-026 The total latency from the Start edge to the HiOut/LoOut update edge SHALL be latency+3 edges (DIV default: 36).
REQ-027 In IDLE, at an edge with Start=1 and Op=DIV and RtVal==0, the block SHALL assert no DivControl, leave HiOut/LoOut unchanged, stay in IDLE, and pulse DivZeroExc in the next cycle.
REQ-028 In IDLE, at an edge with Start=1 and Op=MTHI, the block SHALL load HiOut=RsVal at that edge, raise no Busy, Done or unit pulse, and leave LoOut unchanged.
REQ-029 MTLO SHALL behave as REQ-028, but loading LoOut instead of HiOut.
REQ-030 At an edge with Abort=1 in LAUNCH, RUN or COMMIT, the block SHALL go to IDLE with no commit, assert no Done, and pulse UnitReset in the next cycle.
REQ-031 If Abort and the commit edge coincide, Abort SHALL win.
REQ-032 Abort in IDLE SHALL have no effect, and an Abort+Start edge in IDLE SHALL be treated as a plain Start.
REQ-033 AOut/BOut SHALL be held constant from LAUNCH until the next accepted Start.
REQ-034 A Start in the Done cycle SHALL be accepted, allowing back-to-back operations.

Reset
REQ-035 While Reset=1, the state SHALL be IDLE and the counter 0, independent of clk.
REQ-036 While Reset=1, HiOut, LoOut, AOut and BOut SHALL all be 0.
REQ-037 While Reset=1, MultControl, DivControl, UnitReset, Busy, Done and DivZeroExc SHALL all be 0.
REQ-038 Reset asserted mid-operation SHALL discard the operation, with no Done and no Hi/Lo update.

Verification
REQ-039 DIV, RsVal=100, RtVal=7, unit model returning Hi=2, Lo=14 -> DivControl 1 cycle after Start, Busy 36 cycles, Done once, HiOut=2, LoOut=14.
REQ-040 DIV, RsVal=5, RtVal=0 -> DivZeroExc 1 cycle, DivControl never set, Busy never set, Hi/Lo unchanged.
REQ-041 MTHI RsVal=0xDEADBEEF, then MTLO RsVal=0x1 -> HiOut=0xDEADBEEF, LoOut=0x1, Busy and Done never set.
REQ-042 MULT started, then Start DIV 5 cycles later -> second Start ignored, only MultControl pulses, commit from Mult inputs.
REQ-043 DIV started, then Abort 10 cycles later -> IDLE next edge, UnitReset 1 cycle, no Done, Hi/Lo unchanged; new DIV then completes normally.
REQ-044 Reset asserted asynchronously mid-RUN -> all outputs 0 immediately; after release, Start MULT completes in MULT_LATENCY+3 edges.

Source files
------------

// File: rtl/hilo_sequencer.sv
// Hi/Lo sequencer: launches the external multiplier/divider, waits out the fixed
// latency, commits the selected unit's result, and handles MTHI/MTLO, abort and div-by-zero.
module hilo_sequencer #(
    parameter int unsigned DIV_LATENCY  = 33,
    parameter int unsigned MULT_LATENCY = 33
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] RsVal,
    input  logic [31:0] RtVal,
    input  logic        Abort,
    input  logic [31:0] MultHiIn,
    input  logic [31:0] MultLoIn,
    input  logic [31:0] DivHiIn,
    input  logic [31:0] DivLoIn,
    output logic [31:0] AOut,
    output logic [31:0] BOut,
    output logic        MultControl,
    output logic        DivControl,
    output logic        UnitReset,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        Busy,
    output logic        Done,
    output logic        DivZeroExc
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 6;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        COMMIT = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_mult_q, op_mult_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                mult_ctl_q, mult_ctl_d;
    logic                div_ctl_q, div_ctl_d;
    logic                unit_rst_q, unit_rst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                dz_q, dz_d;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_mult_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mult_ctl_q <= 1'b0;
            div_ctl_q  <= 1'b0;
            unit_rst_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_mult_q  <= op_mult_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mult_ctl_q <= mult_ctl_d;
            div_ctl_q  <= div_ctl_d;
            unit_rst_q <= unit_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
        end
    end

    // Unit launch pulses are registered on the accept edge so they are high during LAUNCH.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_mult_d  = op_mult_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mult_ctl_d = 1'b0;
        div_ctl_d  = 1'b0;
        unit_rst_d = 1'b0;
        done_d     = 1'b0;
        dz_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT: begin
                            a_d        = RsVal;
                            b_d        = RtVal;
                            op_mult_d  = 1'b1;
                            mult_ctl_d = 1'b1;
                            state_d    = LAUNCH;
                        end
                        OP_DIV: begin
                            if (RtVal != '0) begin
                                a_d       = RsVal;
                                b_d       = RtVal;
                                op_mult_d = 1'b0;
                                div_ctl_d = 1'b1;
                                state_d   = LAUNCH;
                            end else begin
                                dz_d = 1'b1;
                            end
                        end
                        OP_MTHI: hi_d = RsVal;
                        OP_MTLO: lo_d = RsVal;
                        default: ;
                    endcase
                end
            end
            LAUNCH: begin
                cnt_d   = op_mult_q ? CNT_W'(MULT_LATENCY) : CNT_W'(DIV_LATENCY);
                state_d = RUN;
            end
            RUN: begin
                // Counter is seen at zero for one edge before moving on, giving latency+3 overall.
                if (cnt_q == '0) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            COMMIT: begin
                hi_d    = op_mult_q ? MultHiIn : DivHiIn;
                lo_d    = op_mult_q ? MultLoIn : DivLoIn;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything outside IDLE, including the commit edge.
        if (Abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            cnt_d      = '0;
            hi_d       = hi_q;
            lo_d       = lo_q;
            done_d     = 1'b0;
            unit_rst_d = 1'b1;
        end

        busy_d = (state_d != IDLE);
    end

    assign AOut        = a_q;
    assign BOut        = b_q;
    assign MultControl = mult_ctl_q;
    assign DivControl  = div_ctl_q;
    assign UnitReset   = unit_rst_q;
    assign HiOut       = hi_q;
    assign LoOut       = lo_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign DivZeroExc  = dz_q;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Scoreboard bench for hilo_sequencer: stimulus pushes expected Done/DivZeroExc/UnitReset
// events; a negedge monitor pops and checks them as the DUT raises them.
module tb_hilo_sequencer;

    localparam int unsigned DIV_LAT  = 33;
    localparam int unsigned MULT_LAT = 5;

    localparam int K_DONE = 0;
    localparam int K_DZ   = 1;
    localparam int K_UR   = 2;

    typedef struct {
        int          kind;
        logic [31:0] hi;
        logic [31:0] lo;
    } ev_t;

    logic        clk = 1'b0;
    logic        Reset, Start, Abort;
    logic [1:0]  Op;
    logic [31:0] RsVal, RtVal;
    logic [31:0] MultHiIn, MultLoIn, DivHiIn, DivLoIn;
    logic [31:0] AOut, BOut, HiOut, LoOut;
    logic        MultControl, DivControl, UnitReset, Busy, Done, DivZeroExc;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  mult_cnt = 0, div_cnt = 0, busy_cnt = 0, done_cnt = 0;

    hilo_sequencer #(.DIV_LATENCY(DIV_LAT), .MULT_LATENCY(MULT_LAT)) dut (
        .clk(clk), .Reset(Reset), .Start(Start), .Op(Op), .RsVal(RsVal), .RtVal(RtVal),
        .Abort(Abort), .MultHiIn(MultHiIn), .MultLoIn(MultLoIn), .DivHiIn(DivHiIn),
        .DivLoIn(DivLoIn), .AOut(AOut), .BOut(BOut), .MultControl(MultControl),
        .DivControl(DivControl), .UnitReset(UnitReset), .HiOut(HiOut), .LoOut(LoOut),
        .Busy(Busy), .Done(Done), .DivZeroExc(DivZeroExc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, req);
        end
    endtask

    task automatic pop_check(input int kind, input string nm);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: unexpected event, scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            chk({nm, "_kind"}, 32'(kind), 32'(e.kind));
            if (kind == K_DONE) begin
                chk({nm, "_hi"}, HiOut, e.hi);
                chk({nm, "_lo"}, LoOut, e.lo);
            end
        end
    endtask

    // Monitor: tally pulses and match events against the scoreboard.
    always @(negedge clk) begin
        if (!Reset) begin
            mult_cnt += int'(MultControl);
            div_cnt  += int'(DivControl);
            busy_cnt += int'(Busy);
            done_cnt += int'(Done);
            if (Done)       pop_check(K_DONE, "done");
            if (DivZeroExc) pop_check(K_DZ, "divzero");
            if (UnitReset)  pop_check(K_UR, "unitreset");
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [31:0] hi, input logic [31:0] lo);
        ev_t e;
        e.kind = kind;
        e.hi   = hi;
        e.lo   = lo;
        exp_q.push_back(e);
    endtask

    // Called just after a negedge; the following posedge samples the request.
    task automatic do_start(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt);
        Start = 1'b1;
        Op    = op;
        RsVal = rs;
        RtVal = rt;
        step();
        Start = 1'b0;
        Abort = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!Done && k < 200) begin
            step();
            k++;
        end
        if (!Done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: timeout after %0d cycles", k);
        end
    endtask

    int k, b0, d0, m0, dn0;

    initial begin
        Reset = 1'b0; Start = 1'b0; Abort = 1'b0; Op = 2'b00; RsVal = '0; RtVal = '0;
        MultHiIn = '0; MultLoIn = '0; DivHiIn = '0; DivLoIn = '0;
        #1 Reset = 1'b1;
        #2;
        chk("rst_hi", HiOut, 32'h0);
        chk("rst_lo", LoOut, 32'h0);
        chk("rst_ab", AOut | BOut, 32'h0);
        chk("rst_pulses", 32'({MultControl, DivControl, UnitReset, Busy, Done, DivZeroExc}), 32'h0);
        step();
        step();
        Reset = 1'b0;
        step();

        // DIV 100/7: remainder in Hi, quotient in Lo
        DivHiIn = 32'd2; DivLoIn = 32'd14;
        b0 = busy_cnt; d0 = div_cnt; m0 = mult_cnt;
        push(K_DONE, 32'd2, 32'd14);
        do_start(2'b01, 32'd100, 32'd7);
        chk("div_ctl_launch", 32'(DivControl), 32'd1);
        chk("div_busy_launch", 32'(Busy), 32'd1);
        wait_done(k);
        chk("div_latency", 32'(k), 32'(DIV_LAT + 3));
        chk("div_busy_cycles", 32'(busy_cnt - b0), 32'(DIV_LAT + 3));
        chk("div_ctl_pulses", 32'(div_cnt - d0), 32'd1);
        chk("div_no_mult", 32'(mult_cnt - m0), 32'd0);
        chk("div_a", AOut, 32'd100);
        chk("div_b", BOut, 32'd7);
        step();

        // DIV by zero
        b0 = busy_cnt; d0 = div_cnt;
        push(K_DZ, 32'h0, 32'h0);
        do_start(2'b01, 32'd5, 32'd0);
        chk("dz_pulse", 32'(DivZeroExc), 32'd1);
        step(); step(); step();
        chk("dz_no_divctl", 32'(div_cnt - d0), 32'd0);
        chk("dz_no_busy", 32'(busy_cnt - b0), 32'd0);
        chk("dz_hi", HiOut, 32'd2);
        chk("dz_lo", LoOut, 32'd14);
        chk("dz_a_held", AOut, 32'd100);

        // MTHI then MTLO
        b0 = busy_cnt; dn0 = done_cnt;
        do_start(2'b10, 32'hDEADBEEF, 32'h0);
        chk("mthi_hi", HiOut, 32'hDEADBEEF);
        chk("mthi_lo_kept", LoOut, 32'd14);
        do_start(2'b11, 32'h1, 32'h0);
        step();
        chk("mtlo_hi", HiOut, 32'hDEADBEEF);
        chk("mtlo_lo", LoOut, 32'h1);
        chk("mt_no_busy", 32'(busy_cnt - b0), 32'd0);
        chk("mt_no_done", 32'(done_cnt - dn0), 32'd0);

        // MULT with a DIV start 5 cycles later that must be ignored
        MultHiIn = 32'hAAAA0000; MultLoIn = 32'h0000000C;
        d0 = div_cnt; m0 = mult_cnt;
        push(K_DONE, 32'hAAAA0000, 32'h0000000C);
        do_start(2'b00, 32'd3, 32'd4);
        chk("mult_ctl_launch", 32'(MultControl), 32'd1);
        step(); step(); step(); step();
        do_start(2'b01, 32'd9, 32'd3);
        wait_done(k);
        chk("mult_ign_divctl", 32'(div_cnt - d0), 32'd0);
        chk("mult_ctl_pulses", 32'(mult_cnt - m0), 32'd1);
        chk("mult_a_held", AOut, 32'd3);
        chk("mult_b_held", BOut, 32'd4);
        step();

        // DIV aborted 10 cycles in
        DivHiIn = 32'd99; DivLoIn = 32'd99;
        dn0 = done_cnt;
        push(K_UR, 32'h0, 32'h0);
        do_start(2'b01, 32'd50, 32'd5);
        repeat (9) step();
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_unitreset", 32'(UnitReset), 32'd1);
        repeat (40) step();
        chk("abort_no_done", 32'(done_cnt - dn0), 32'd0);
        chk("abort_hi", HiOut, 32'hAAAA0000);

        // Fresh DIV 10/3 completes normally
        DivHiIn = 32'd1; DivLoIn = 32'd3;
        push(K_DONE, 32'd1, 32'd3);
        do_start(2'b01, 32'd10, 32'd3);
        wait_done(k);
        chk("div2_latency", 32'(k), 32'(DIV_LAT + 3));
        step();

        // Abort on the commit edge wins
        DivHiIn = 32'h55; DivLoIn = 32'h66;
        dn0 = done_cnt;
        push(K_UR, 32'h0, 32'h0);
        do_start(2'b01, 32'd7, 32'd2);
        repeat (DIV_LAT + 2) step();
        chk("commit_busy", 32'(Busy), 32'd1);
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        step();
        chk("commit_abort_no_done", 32'(done_cnt - dn0), 32'd0);
        chk("commit_abort_hi", HiOut, 32'd1);
        chk("commit_abort_lo", LoOut, 32'd3);

        // Async reset mid-RUN discards the MULT
        do_start(2'b00, 32'd6, 32'd7);
        repeat (3) step();
        #2 Reset = 1'b1;
        #1;
        chk("mrst_hi", HiOut, 32'h0);
        chk("mrst_lo", LoOut, 32'h0);
        chk("mrst_ab", AOut | BOut, 32'h0);
        chk("mrst_pulses", 32'({MultControl, DivControl, UnitReset, Busy, Done, DivZeroExc}), 32'h0);
        step();
        Reset = 1'b0;
        step();

        // Abort+Start in IDLE is a plain start; then back-to-back DIV in the Done cycle
        MultHiIn = 32'h12345678; MultLoIn = 32'h9ABCDEF0;
        DivHiIn = 32'd2; DivLoIn = 32'd14;
        push(K_DONE, 32'h12345678, 32'h9ABCDEF0);
        Abort = 1'b1;
        do_start(2'b00, 32'd11, 32'd13);
        chk("idle_abort_start_busy", 32'(Busy), 32'd1);
        wait_done(k);
        chk("mult_latency", 32'(k), 32'(MULT_LAT + 3));
        push(K_DONE, 32'd2, 32'd14);
        do_start(2'b01, 32'd100, 32'd7);
        chk("b2b_divctl", 32'(DivControl), 32'd1);
        wait_done(k);
        chk("b2b_latency", 32'(k), 32'(DIV_LAT + 3));
        repeat (3) step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
